// File: rtl/myio_gpio_pkg.sv
// Shared constants and types for the GPIO block: register offsets, AXI responses, payload structs.
package myio_gpio_pkg;

    localparam int unsigned AXI_DW = 32;
    localparam int unsigned AXI_AW = 8;

    // Byte offsets inside a channel's 16-byte window
    localparam logic [3:0] OFF_OUT = 4'h0;
    localparam logic [3:0] OFF_DIR = 4'h4;
    localparam logic [3:0] OFF_IN  = 4'h8;
    localparam logic [3:0] OFF_ISR = 4'hC;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    // Per-channel register view, zero-extended to the bus width
    typedef struct packed {
        logic [AXI_DW-1:0] out_v;
        logic [AXI_DW-1:0] dir_v;
        logic [AXI_DW-1:0] in_v;
        logic [AXI_DW-1:0] isr_v;
    } chan_regs_t;

    // Result of an address decode
    typedef struct packed {
        logic       hit;
        logic       ier;
        logic [1:0] ch;
        logic [3:0] off;
    } dec_t;

endpackage

// File: rtl/myio_gpio_chan.sv
// One GPIO channel: OUT/DIR registers, input synchroniser, rising-edge detect and W1C ISR.
module myio_gpio_chan
    import myio_gpio_pkg::*;
#(
    parameter int unsigned GPIO_WIDTH = 16,
    parameter logic [31:0] RST_OUT    = 32'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [GPIO_WIDTH-1:0] pin,
    input  logic                  wr_out,
    input  logic                  wr_dir,
    input  logic                  wr_isr,
    input  logic [GPIO_WIDTH-1:0] wmask,
    input  logic [GPIO_WIDTH-1:0] wdata,
    output chan_regs_t            regs,
    output logic [GPIO_WIDTH-1:0] pin_o,
    output logic [GPIO_WIDTH-1:0] pin_t
);

    logic [GPIO_WIDTH-1:0] out_q;
    logic [GPIO_WIDTH-1:0] dir_q;
    logic [GPIO_WIDTH-1:0] sync1_q;
    logic [GPIO_WIDTH-1:0] sync2_q;
    logic [GPIO_WIDTH-1:0] prev_q;
    logic [GPIO_WIDTH-1:0] isr_q;
    logic [GPIO_WIDTH-1:0] rise_c;
    logic [GPIO_WIDTH-1:0] clr_c;

    // Edge detect on the synchronised pins; history always tracks the synchroniser output
    assign rise_c = sync2_q & ~prev_q;
    assign clr_c  = wr_isr ? (wdata & wmask) : '0;

    // Channel registers; a same-cycle new edge wins over a W1C clear
    always_ff @(posedge clk) begin
        if (rst) begin
            out_q   <= RST_OUT[GPIO_WIDTH-1:0];
            dir_q   <= '1;
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= '0;
            isr_q   <= '0;
        end else begin
            sync1_q <= pin;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            isr_q   <= (isr_q & ~clr_c) | rise_c;
            if (wr_out) out_q <= (out_q & ~wmask) | (wdata & wmask);
            if (wr_dir) dir_q <= (dir_q & ~wmask) | (wdata & wmask);
        end
    end

    assign pin_o      = out_q;
    assign pin_t      = dir_q;
    assign regs.out_v = AXI_DW'(out_q);
    assign regs.dir_v = AXI_DW'(dir_q);
    assign regs.in_v  = AXI_DW'(sync2_q);
    assign regs.isr_v = AXI_DW'(isr_q);

endmodule

// File: rtl/myio_gpio_v2.sv
// AXI4-Lite GPIO controller: handshakes, address decode, IER and irq; channels in myio_gpio_chan.
module myio_gpio_v2
    import myio_gpio_pkg::*;
#(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned GPIO_WIDTH = 16,
    parameter logic [31:0] RST_OUT    = 32'h0
) (
    input  logic                         ACLK,
    input  logic                         ARESET,
    input  logic [AXI_AW-1:0]            S_AXI_AWADDR,
    input  logic [2:0]                   S_AXI_AWPROT,
    input  logic                         S_AXI_AWVALID,
    output logic                         S_AXI_AWREADY,
    input  logic [AXI_DW-1:0]            S_AXI_WDATA,
    input  logic [3:0]                   S_AXI_WSTRB,
    input  logic                         S_AXI_WVALID,
    output logic                         S_AXI_WREADY,
    output logic [1:0]                   S_AXI_BRESP,
    output logic                         S_AXI_BVALID,
    input  logic                         S_AXI_BREADY,
    input  logic [AXI_AW-1:0]            S_AXI_ARADDR,
    input  logic [2:0]                   S_AXI_ARPROT,
    input  logic                         S_AXI_ARVALID,
    output logic                         S_AXI_ARREADY,
    output logic [AXI_DW-1:0]            S_AXI_RDATA,
    output logic [1:0]                   S_AXI_RRESP,
    output logic                         S_AXI_RVALID,
    input  logic                         S_AXI_RREADY,
    input  logic [NUM_CH*GPIO_WIDTH-1:0] gpio_i,
    output logic [NUM_CH*GPIO_WIDTH-1:0] gpio_o,
    output logic [NUM_CH*GPIO_WIDTH-1:0] gpio_t,
    output logic                         irq
);

    logic              aw_ready_q;
    logic              b_valid_q;
    logic [1:0]        b_resp_q;
    logic              ar_ready_q;
    logic              r_valid_q;
    logic [AXI_DW-1:0] r_data_q;
    logic [1:0]        r_resp_q;
    logic [NUM_CH-1:0] ier_q;
    logic              irq_q;

    dec_t                  wdec_c;
    dec_t                  rdec_c;
    logic                  wr_en_c;
    logic [GPIO_WIDTH-1:0] wmask_c;
    logic [NUM_CH-1:0]     ier_mask_c;
    logic [NUM_CH-1:0]     isr_any_c;
    logic [AXI_DW-1:0]     rd_data_c;
    chan_regs_t            regs [NUM_CH];

    // Protection bits, address LSBs and out-of-range data/strobe lanes carry no meaning here
    logic unused_bits;
    assign unused_bits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0],
                           S_AXI_ARADDR[1:0], S_AXI_WDATA, S_AXI_WSTRB};

    // Map a byte address onto channel/offset or the global IER slot
    function automatic dec_t decode(input logic [AXI_AW-1:0] a);
        dec_t d;
        d     = '0;
        d.ch  = a[5:4];
        d.off = {a[3:2], 2'b00};
        if (32'(a[7:4]) < NUM_CH) begin
            d.hit = 1'b1;
        end else if (32'(a[7:4]) == NUM_CH && a[3:2] == 2'b00) begin
            d.hit = 1'b1;
            d.ier = 1'b1;
        end
        return d;
    endfunction

    assign wdec_c     = decode(S_AXI_AWADDR);
    assign rdec_c     = decode(S_AXI_ARADDR);
    assign wr_en_c    = aw_ready_q;
    assign ier_mask_c = {NUM_CH{S_AXI_WSTRB[0]}};

    for (genvar i = 0; i < GPIO_WIDTH; i++) begin : g_mask
        assign wmask_c[i] = S_AXI_WSTRB[i/8];
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic sel_c;
        assign sel_c = wr_en_c && wdec_c.hit && !wdec_c.ier && (wdec_c.ch == 2'(c));

        myio_gpio_chan #(
            .GPIO_WIDTH (GPIO_WIDTH),
            .RST_OUT    (RST_OUT)
        ) u_chan (
            .clk    (ACLK),
            .rst    (ARESET),
            .pin    (gpio_i[c*GPIO_WIDTH +: GPIO_WIDTH]),
            .wr_out (sel_c && (wdec_c.off == OFF_OUT)),
            .wr_dir (sel_c && (wdec_c.off == OFF_DIR)),
            .wr_isr (sel_c && (wdec_c.off == OFF_ISR)),
            .wmask  (wmask_c),
            .wdata  (S_AXI_WDATA[GPIO_WIDTH-1:0]),
            .regs   (regs[c]),
            .pin_o  (gpio_o[c*GPIO_WIDTH +: GPIO_WIDTH]),
            .pin_t  (gpio_t[c*GPIO_WIDTH +: GPIO_WIDTH])
        );
    end

    // Read mux and per-channel pending summary
    always_comb begin
        rd_data_c = '0;
        isr_any_c = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            isr_any_c[c] = |regs[c].isr_v;
            if (rdec_c.hit && !rdec_c.ier && rdec_c.ch == 2'(c)) begin
                case (rdec_c.off)
                    OFF_OUT: rd_data_c = regs[c].out_v;
                    OFF_DIR: rd_data_c = regs[c].dir_v;
                    OFF_IN:  rd_data_c = regs[c].in_v;
                    default: rd_data_c = regs[c].isr_v;
                endcase
            end
        end
        if (rdec_c.hit && rdec_c.ier) rd_data_c = AXI_DW'(ier_q);
    end

    // AXI handshakes, IER and registered irq
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            aw_ready_q <= 1'b0;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
            ar_ready_q <= 1'b0;
            r_valid_q  <= 1'b0;
            r_data_q   <= '0;
            r_resp_q   <= RESP_OKAY;
            ier_q      <= '0;
            irq_q      <= 1'b0;
        end else begin
            aw_ready_q <= S_AXI_AWVALID && S_AXI_WVALID && !b_valid_q && !aw_ready_q;
            if (aw_ready_q) begin
                b_valid_q <= 1'b1;
                b_resp_q  <= wdec_c.hit ? RESP_OKAY : RESP_SLVERR;
            end else if (S_AXI_BREADY) begin
                b_valid_q <= 1'b0;
            end

            ar_ready_q <= S_AXI_ARVALID && !r_valid_q && !ar_ready_q;
            if (ar_ready_q) begin
                r_valid_q <= 1'b1;
                r_data_q  <= rd_data_c;
                r_resp_q  <= rdec_c.hit ? RESP_OKAY : RESP_SLVERR;
            end else if (S_AXI_RREADY) begin
                r_valid_q <= 1'b0;
            end

            if (wr_en_c && wdec_c.ier) begin
                ier_q <= (ier_q & ~ier_mask_c) | (S_AXI_WDATA[NUM_CH-1:0] & ier_mask_c);
            end
            irq_q <= |(ier_q & isr_any_c);
        end
    end

    assign S_AXI_AWREADY = aw_ready_q;
    assign S_AXI_WREADY  = aw_ready_q;
    assign S_AXI_BVALID  = b_valid_q;
    assign S_AXI_BRESP   = b_resp_q;
    assign S_AXI_ARREADY = ar_ready_q;
    assign S_AXI_RVALID  = r_valid_q;
    assign S_AXI_RDATA   = r_data_q;
    assign S_AXI_RRESP   = r_resp_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_myio_gpio_v2.sv
// Directed bench for myio_gpio_v2 with response scoreboards for the B and R channels.
module tb_myio_gpio_v2;

    localparam int unsigned NUM_CH = 2;
    localparam int unsigned GW     = 16;
    localparam int unsigned PW     = NUM_CH * GW;
    localparam logic [1:0]  OKAY   = 2'b00;
    localparam logic [1:0]  SLVERR = 2'b10;

    logic          ACLK = 1'b0;
    logic          ARESET;
    logic [7:0]    AWADDR;
    logic [2:0]    AWPROT;
    logic          AWVALID;
    logic          AWREADY;
    logic [31:0]   WDATA;
    logic [3:0]    WSTRB;
    logic          WVALID;
    logic          WREADY;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY;
    logic [7:0]    ARADDR;
    logic [2:0]    ARPROT;
    logic          ARVALID;
    logic          ARREADY;
    logic [31:0]   RDATA;
    logic [1:0]    RRESP;
    logic          RVALID;
    logic          RREADY;
    logic [PW-1:0] gpio_i;
    logic [PW-1:0] gpio_o;
    logic [PW-1:0] gpio_t;
    logic          irq;

    int          checks   = 0;
    int          failures = 0;
    logic [1:0]  wr_q[$];
    logic [33:0] rd_q[$];
    logic        irq_at_b;

    myio_gpio_v2 #(.NUM_CH(NUM_CH), .GPIO_WIDTH(GW), .RST_OUT(32'h0)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_AXI_AWADDR(AWADDR), .S_AXI_AWPROT(AWPROT), .S_AXI_AWVALID(AWVALID), .S_AXI_AWREADY(AWREADY),
        .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB), .S_AXI_WVALID(WVALID), .S_AXI_WREADY(WREADY),
        .S_AXI_BRESP(BRESP), .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
        .S_AXI_ARADDR(ARADDR), .S_AXI_ARPROT(ARPROT), .S_AXI_ARVALID(ARVALID), .S_AXI_ARREADY(ARREADY),
        .S_AXI_RDATA(RDATA), .S_AXI_RRESP(RRESP), .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY),
        .gpio_i(gpio_i), .gpio_o(gpio_o), .gpio_t(gpio_t), .irq(irq)
    );

    always #5 ACLK = ~ACLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic aw_issue(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] er);
        int n;
        wr_q.push_back(er);
        AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
        n = 0;
        while (AWREADY !== 1'b1 && n < 40) begin tick(); n++; end
        check("awready_seen", 32'(AWREADY), 32'd1);
        check("wready_with_aw", 32'(WREADY), 32'd1);
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
    endtask

    task automatic b_collect(input string tag);
        int n;
        logic [1:0] er;
        BREADY = 1'b1;
        n = 0;
        while (BVALID !== 1'b1 && n < 40) begin tick(); n++; end
        check({tag, "_bvalid"}, 32'(BVALID), 32'd1);
        irq_at_b = irq;
        er = (wr_q.size() > 0) ? wr_q.pop_front() : 2'bxx;
        check({tag, "_bresp"}, 32'(BRESP), 32'(er));
        tick();
        BREADY = 1'b0;
        check({tag, "_bdone"}, 32'(BVALID), 32'd0);
    endtask

    task automatic ar_issue(input logic [7:0] a, input logic [31:0] ed, input logic [1:0] er);
        int n;
        rd_q.push_back({er, ed});
        ARADDR = a; ARVALID = 1'b1;
        n = 0;
        while (ARREADY !== 1'b1 && n < 40) begin tick(); n++; end
        check("arready_seen", 32'(ARREADY), 32'd1);
        tick();
        ARVALID = 1'b0;
    endtask

    task automatic r_collect(input string tag);
        int n;
        logic [33:0] e;
        RREADY = 1'b1;
        n = 0;
        while (RVALID !== 1'b1 && n < 40) begin tick(); n++; end
        check({tag, "_rvalid"}, 32'(RVALID), 32'd1);
        e = (rd_q.size() > 0) ? rd_q.pop_front() : 34'bx;
        check({tag, "_rdata"}, RDATA, e[31:0]);
        check({tag, "_rresp"}, 32'(RRESP), 32'(e[33:32]));
        tick();
        RREADY = 1'b0;
        check({tag, "_rdone"}, 32'(RVALID), 32'd0);
    endtask

    task automatic wr(input string tag, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, input logic [1:0] er);
        aw_issue(a, d, s, er);
        b_collect(tag);
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] ed,
                      input logic [1:0] er);
        ar_issue(a, ed, er);
        r_collect(tag);
    endtask

    initial begin
        int seen;
        ARESET = 1'b1; AWADDR = '0; AWPROT = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0;
        WVALID = 1'b0; BREADY = 1'b0; ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
        gpio_i = '0;
        repeat (3) tick();
        check("rst_awready", 32'(AWREADY), 32'd0);
        check("rst_bvalid", 32'(BVALID), 32'd0);
        check("rst_arready", 32'(ARREADY), 32'd0);
        check("rst_rvalid", 32'(RVALID), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_gpio_t", gpio_t, 32'hFFFF_FFFF);
        check("rst_gpio_o", gpio_o, 32'h0);
        ARESET = 1'b0;
        tick();

        // Byte-lane writes to OUT
        wr("out_a5", 8'h00, 32'h0000_A5A5, 4'h1, OKAY);
        rd("out_a5", 8'h00, 32'h0000_00A5, OKAY);
        check("gpio_o_a5", 32'(gpio_o[15:0]), 32'h00A5);
        wr("out_lane1", 8'h00, 32'h1234_5678, 4'h2, OKAY);
        rd("out_lane1", 8'h00, 32'h0000_56A5, OKAY);
        wr("out1_full", 8'h10, 32'hDEAD_BEEF, 4'hF, OKAY);
        rd("out1_full", 8'h10, 32'h0000_BEEF, OKAY);
        check("gpio_o_ch1", 32'(gpio_o[31:16]), 32'hBEEF);

        // DIR drives gpio_t
        wr("dir_f0", 8'h04, 32'h0000_00F0, 4'h3, OKAY);
        rd("dir_f0", 8'h04, 32'h0000_00F0, OKAY);
        check("gpio_t_f0", 32'(gpio_t[15:0]), 32'h00F0);
        wr("dir_ff", 8'h04, 32'h0000_FFFF, 4'h3, OKAY);
        rd("dir1", 8'h14, 32'h0000_FFFF, OKAY);
        wr("ier1", 8'h20, 32'h0000_0001, 4'hF, OKAY);
        rd("ier1", 8'h20, 32'h0000_0001, OKAY);

        // Edge on pin 3: irq rises four clocks after the pin change
        gpio_i[3] = 1'b1;
        tick(); check("irq_lat1", 32'(irq), 32'd0);
        tick();
        tick(); check("irq_lat3", 32'(irq), 32'd0);
        tick(); check("irq_lat4", 32'(irq), 32'd1);
        rd("in_bit3", 8'h08, 32'h0000_0008, OKAY);
        rd("isr_bit3", 8'h0C, 32'h0000_0008, OKAY);

        // W1C collides with a new edge: the set wins
        gpio_i[3] = 1'b0;
        repeat (4) tick();
        gpio_i[3] = 1'b1;
        tick();
        wr_q.push_back(OKAY);
        AWADDR = 8'h0C; WDATA = 32'h8; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
        tick();
        check("race_awready", 32'(AWREADY), 32'd1);
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        b_collect("race");
        check("race_irq_b", 32'(irq_at_b), 32'd1);
        rd("race_isr", 8'h0C, 32'h0000_0008, OKAY);
        check("race_irq", 32'(irq), 32'd1);
        wr("w1c", 8'h0C, 32'h0000_0008, 4'hF, OKAY);
        check("w1c_irq_still", 32'(irq_at_b), 32'd1);
        check("w1c_irq_drop", 32'(irq), 32'd0);
        rd("w1c_isr", 8'h0C, 32'h0, OKAY);

        // Undecoded addresses and read-only writes
        rd("bad_rd", 8'h24, 32'h0, SLVERR);
        wr("bad_wr", 8'h30, 32'hFFFF_FFFF, 4'hF, SLVERR);
        wr("in_wr", 8'h08, 32'h0000_FFFF, 4'hF, OKAY);
        rd("in_keep", 8'h08, 32'h0000_0008, OKAY);
        rd("out_keep", 8'h00, 32'h0000_56A5, OKAY);
        rd("ier_keep", 8'h20, 32'h0000_0001, OKAY);
        rd("dir_keep", 8'h04, 32'h0000_FFFF, OKAY);

        // Channel 1 pins: ISR gated by IER
        gpio_i[31:16] = 16'hC3A5;
        repeat (5) tick();
        check("ch1_irq_masked", 32'(irq), 32'd0);
        rd("ch1_in", 8'h18, 32'h0000_C3A5, OKAY);
        rd("ch1_isr", 8'h1C, 32'h0000_C3A5, OKAY);
        wr("ch1_w1c", 8'h1C, 32'h0000_00FF, 4'h1, OKAY);
        rd("ch1_isr_part", 8'h1C, 32'h0000_C300, OKAY);
        wr("ier3", 8'h20, 32'h0000_0003, 4'hF, OKAY);
        tick();
        check("ch1_irq_on", 32'(irq), 32'd1);
        wr("ch1_clr", 8'h1C, 32'h0000_FFFF, 4'h3, OKAY);
        check("ch1_irq_off", 32'(irq), 32'd0);

        // B backpressure blocks the next write
        aw_issue(8'h00, 32'h0000_005A, 4'h1, OKAY);
        repeat (10) tick();
        check("bp_bvalid_held", 32'(BVALID), 32'd1);
        check("bp_bresp_held", 32'(BRESP), 32'(OKAY));
        AWADDR = 8'h04; WDATA = 32'h0000_0F0F; WSTRB = 4'h3; AWVALID = 1'b1; WVALID = 1'b1;
        seen = 0;
        repeat (5) begin tick(); if (AWREADY === 1'b1) seen++; end
        check("bp_no_awready", 32'(seen), 32'd0);
        b_collect("bp1");
        aw_issue(8'h04, 32'h0000_0F0F, 4'h3, OKAY);
        b_collect("bp2");
        rd("bp_out", 8'h00, 32'h0000_565A, OKAY);
        rd("bp_dir", 8'h04, 32'h0000_0F0F, OKAY);

        // Reset while a read response is pending
        gpio_i = '0;
        ar_issue(8'h00, 32'h0000_565A, OKAY);
        tick();
        check("pend_rvalid", 32'(RVALID), 32'd1);
        ARESET = 1'b1;
        tick();
        check("mrst_rvalid", 32'(RVALID), 32'd0);
        check("mrst_irq", 32'(irq), 32'd0);
        check("mrst_gpio_t", gpio_t, 32'hFFFF_FFFF);
        check("mrst_gpio_o", gpio_o, 32'h0);
        rd_q.delete();
        ARESET = 1'b0;
        RREADY = 1'b1;
        repeat (3) tick();
        check("mrst_no_resp", 32'(RVALID), 32'd0);
        RREADY = 1'b0;
        rd("mrst_dir", 8'h04, 32'h0000_FFFF, OKAY);
        rd("mrst_out", 8'h00, 32'h0, OKAY);
        rd("mrst_ier", 8'h20, 32'h0, OKAY);
        rd("mrst_isr1", 8'h1C, 32'h0, OKAY);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/myio_gpio_v2.md
MYIO_GPIO_V2 -- requirements
Module: myio_gpio_v2

Interface
REQ-001 SHALL have parameter NUM_CH, default 2, meaning the number of GPIO channels (legal 1..4).
REQ-002 SHALL have parameter GPIO_WIDTH, default 16, meaning pins per channel (legal 1..32).
REQ-003 SHALL have parameter RST_OUT, default 0, meaning the reset value of every channel OUT register.
REQ-004 SHALL have port ACLK, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port ARESET, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have AXI4-Lite slave ports S_AXI_AW*, W*, B*, AR*, R*: 32-bit data, 4-bit WSTRB, 8-bit address, 2-bit resp; AWPROT and ARPROT are ignored.
REQ-007 SHALL have port gpio_i, input, NUM_CH*GPIO_WIDTH bits: asynchronous pin inputs.
REQ-008 SHALL have port gpio_o, output, NUM_CH*GPIO_WIDTH bits: pin output values.
REQ-009 SHALL have port gpio_t, output, NUM_CH*GPIO_WIDTH bits: tristate, where 1 means the pin is an input.
REQ-010 SHALL have port irq, output, 1 bit: level interrupt.

Function
REQ-011 SHALL decode a per-channel register map at base c*0x10: +0x0 OUT (RW), +0x4 DIR (RW, drives gpio_t), +0x8 IN (RO), +0xC ISR (W1C); global IER (RW, one bit per channel) at NUM_CH*0x10.
REQ-012 SHALL accept a write only when AWVALID, WVALID and !BVALID are all high, asserting AWREADY and WREADY together for exactly one cycle.
REQ-013 SHALL update registers in the AWREADY cycle and assert BVALID on the next cycle, holding BVALID and BRESP until BREADY is high.
REQ-014 SHALL honour WSTRB per byte lane; lanes at or above GPIO_WIDTH are ignored and read as 0.
REQ-015 SHALL assert ARREADY for one cycle when ARVALID and !RVALID are both high, present RVALID with RDATA on the next cycle, and hold them until RREADY is high.
REQ-016 SHALL respond to an undecoded address with SLVERR (2'b10): writes have no effect and reads return 0; all other accesses respond OKAY.
REQ-017 SHALL synchronise gpio_i through two flops, so that IN reflects a pin change 2 cycles after the edge.
REQ-018 SHALL set ISR bit n on a rising edge of synchronised bit n, one cycle after the IN change.
REQ-019 SHALL give priority to a set when a W1C clear and a new edge hit the same ISR bit in the same cycle.
REQ-020 SHALL drive irq registered as OR over c of (IER[c] AND |ISR[c]).
REQ-021 SHALL ensure writes to IN or to any read-only bit have no effect and respond OKAY.
REQ-022 SHALL process a write and a read in the same cycle independently; a read of a register being written returns the old value.

Reset
REQ-023 SHALL, while ARESET is high, clear all VALID and READY outputs, DIR to all ones, ISR/IER/sync flops to 0, OUT to RST_OUT, and irq to 0.
REQ-024 SHALL abandon any in-flight transaction when ARESET asserts mid-transaction, issuing no response afterwards.
REQ-025 SHALL not raise an ISR bit on the first cycle after reset, because the edge-detect history is preloaded from the synchroniser.

Structure
REQ-026 SHALL place register offsets, the RESP_OKAY and RESP_SLVERR constants, and a channel register struct in package myio_gpio_pkg.
REQ-027 SHALL implement each channel's OUT/DIR/sync/edge/ISR logic in sub-module myio_gpio_chan, instantiated NUM_CH times; AXI handshake and decode logic stays in the top level.
REQ-028 SHALL contain no combinational path from any AXI input to any AXI output.

Verification
REQ-029 SHALL cover this scenario: write 0x0000A5A5 to 0x00 with WSTRB 0x1, then read 0x00 -> RDATA 0x000000A5, gpio_o[15:0] = 0x00A5, and RESP OKAY.
REQ-030 SHALL cover this scenario: with DIR=0xFFFF and IER=0x1, drive a rising edge on gpio_i[3] -> IN bit 3 set after 2 cycles, ISR = 0x8 after 3 cycles, and irq high after 4 cycles.
REQ-031 SHALL cover this scenario: write 0x8 to ISR 0x0C in the same cycle a new edge arrives on bit 3 -> ISR stays 0x8 and irq stays high; a later W1C clears it and irq drops one cycle later.
REQ-032 SHALL cover this scenario: read 0x24 and write 0x30 with NUM_CH=2 -> SLVERR on both, RDATA=0, and no register changes.
REQ-033 SHALL cover this scenario: hold BREADY low for 10 cycles, then issue a second AWVALID -> AWREADY is not asserted until the first B handshake completes.
REQ-034 SHALL cover this scenario: assert ARESET while RVALID is pending -> RVALID is 0 next cycle, DIR reads 0x0000FFFF, and OUT reads RST_OUT.
